// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared lane width, array size and saturating add for the systolic array
package systolic_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 4;

    typedef logic [DATA_W-1:0] lane_t;

    // Signed add clamped to the 16-bit two's complement range.
    function automatic lane_t sat_add(input lane_t x, input lane_t y);
        logic [DATA_W:0] s;
        s = {x[DATA_W-1], x} + {y[DATA_W-1], y};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one weight-stationary MAC cell; SYSTOLIC_PS_SATURATE_EN selects signed saturating accumulate
module systolic_pe
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_clear,
    input  logic              en_a,
    input  logic              en_b,
    input  logic              en_ps,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] ps_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] ps_out
);

    lane_t a_reg;
    lane_t b_reg;
    lane_t ps_reg;
    lane_t product;
    lane_t mac_sum;

    // Low half of the product is identical for signed and unsigned operands.
    always_comb begin
        product = a_reg * b_reg;
`ifdef SYSTOLIC_PS_SATURATE_EN
        mac_sum = sat_add(ps_in, product);
`else
        mac_sum = ps_in + product;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n || data_clear) begin
            a_reg  <= '0;
            b_reg  <= '0;
            ps_reg <= '0;
        end else begin
            if (en_a) begin
                a_reg <= a_in;
            end
            if (en_b) begin
                b_reg <= b_in;
            end
            if (en_ps) begin
                ps_reg <= mac_sum;
            end
        end
    end

    assign a_out  = a_reg;
    assign b_out  = b_reg;
    assign ps_out = ps_reg;

endmodule

// File: rtl/systolic_array_4x4.sv
// rtl/systolic_array_4x4.sv - 4x4 weight-stationary systolic matmul grid; SYSTOLIC_PS_SATURATE_EN enables saturating sums
module systolic_array_4x4
    import systolic_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_clear,
    input  logic                en_b_shift_bottom,
    input  logic                en_shift_right,
    input  logic                en_shift_bottom,
    input  logic [N*DATA_W-1:0] a_left_in_flat,
    input  logic [N*DATA_W-1:0] b_top_in_flat,
    input  logic [N*DATA_W-1:0] ps_top_in_flat,
    output logic [N*DATA_W-1:0] ps_bottom_out_flat
);

    // Index k of each bus is the value entering PE k along that direction.
    lane_t a_bus  [N][N+1];
    lane_t b_bus  [N+1][N];
    lane_t ps_bus [N+1][N];

    logic [2*N*DATA_W-1:0] unused_edge;

    for (genvar r = 0; r < N; r++) begin : g_row_io
        assign a_bus[r][0] = a_left_in_flat[r*DATA_W +: DATA_W];
        assign unused_edge[r*DATA_W +: DATA_W] = a_bus[r][N];
    end

    for (genvar c = 0; c < N; c++) begin : g_col_io
        assign b_bus[0][c]  = b_top_in_flat[c*DATA_W +: DATA_W];
        assign ps_bus[0][c] = ps_top_in_flat[c*DATA_W +: DATA_W];
        assign ps_bottom_out_flat[c*DATA_W +: DATA_W] = ps_bus[N][c];
        assign unused_edge[(N+c)*DATA_W +: DATA_W] = b_bus[N][c];
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe u_pe (
                .clk        (clk),
                .rst_n      (rst_n),
                .data_clear (data_clear),
                .en_a       (en_shift_right),
                .en_b       (en_b_shift_bottom),
                .en_ps      (en_shift_bottom),
                .a_in       (a_bus[r][c]),
                .b_in       (b_bus[r][c]),
                .ps_in      (ps_bus[r][c]),
                .a_out      (a_bus[r][c+1]),
                .b_out      (b_bus[r+1][c]),
                .ps_out     (ps_bus[r+1][c])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb/tb_systolic_array_4x4.sv - scoreboard bench for systolic_array_4x4 against a matrix-level reference model
module tb_systolic_array_4x4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        data_clear = 1'b0;
    logic        en_b_shift_bottom = 1'b0;
    logic        en_shift_right = 1'b0;
    logic        en_shift_bottom = 1'b0;
    logic [63:0] a_left_in_flat = '0;
    logic [63:0] b_top_in_flat = '0;
    logic [63:0] ps_top_in_flat = '0;
    logic [63:0] ps_bottom_out_flat;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    logic [15:0] ma[4][4];
    logic [15:0] mb[4][4];
    logic [15:0] mp[4][4];

    systolic_array_4x4 dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_clear         (data_clear),
        .en_b_shift_bottom  (en_b_shift_bottom),
        .en_shift_right     (en_shift_right),
        .en_shift_bottom    (en_shift_bottom),
        .a_left_in_flat     (a_left_in_flat),
        .b_top_in_flat      (b_top_in_flat),
        .ps_top_in_flat     (ps_top_in_flat),
        .ps_bottom_out_flat (ps_bottom_out_flat)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mac_ref(input logic [15:0] p, input logic [15:0] a,
                                            input logic [15:0] b);
        longint pr;
        longint s;
        pr = (longint'(a) * longint'(b)) % 65536;
`ifdef SYSTOLIC_PS_SATURATE_EN
        if (pr >= 32768) pr = pr - 65536;
        s = (longint'(p) >= 32768) ? longint'(p) - 65536 : longint'(p);
        s = s + pr;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
`else
        s = (longint'(p) + pr) % 65536;
        return 16'(s);
`endif
    endfunction

    function automatic logic [63:0] model_out();
        logic [63:0] o;
        for (int c = 0; c < 4; c++) o[16*c +: 16] = mp[3][c];
        return o;
    endfunction

    // Apply one clock edge's worth of the array rules to the matrices.
    task automatic model_edge();
        logic [15:0] na[4][4];
        logic [15:0] nb[4][4];
        logic [15:0] np[4][4];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                na[r][c] = ma[r][c];
                nb[r][c] = mb[r][c];
                np[r][c] = mp[r][c];
                if (rst_n || data_clear) begin
                    na[r][c] = '0;
                    nb[r][c] = '0;
                    np[r][c] = '0;
                end else begin
                    if (en_shift_right) begin
                        if (c == 0) na[r][c] = a_left_in_flat[16*r +: 16];
                        else        na[r][c] = ma[r][c-1];
                    end
                    if (en_b_shift_bottom) begin
                        if (r == 0) nb[r][c] = b_top_in_flat[16*c +: 16];
                        else        nb[r][c] = mb[r-1][c];
                    end
                    if (en_shift_bottom) begin
                        if (r == 0) np[r][c] = mac_ref(ps_top_in_flat[16*c +: 16], ma[r][c], mb[r][c]);
                        else        np[r][c] = mac_ref(mp[r-1][c], ma[r][c], mb[r][c]);
                    end
                end
            end
        end
        ma = na;
        mb = nb;
        mp = np;
    endtask

    task automatic step(input logic rst, input logic clr, input logic eb, input logic ea,
                        input logic ep, input logic [63:0] a_in, input logic [63:0] b_in,
                        input logic [63:0] ps_in);
        @(negedge clk);
        rst_n             = rst;
        data_clear        = clr;
        en_b_shift_bottom = eb;
        en_shift_right    = ea;
        en_shift_bottom   = ep;
        a_left_in_flat    = a_in;
        b_top_in_flat     = b_in;
        ps_top_in_flat    = ps_in;
        @(posedge clk);
        #1;
        model_edge();
        exp_q.push_back(model_out());
        name_q.push_back("model_step");
    endtask

    task automatic expect_const(input string nm, input logic [63:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic do_reset();  step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
    task automatic do_clear();  step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
    task automatic idle();      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0); endtask
    task automatic shb(input logic [63:0] v); step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, v, '0); endtask
    task automatic shr(input logic [63:0] v); step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, '0, '0); endtask
    task automatic shp(input logic [63:0] v); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, v); endtask

    always @(negedge clk) begin
        logic [63:0] e;
        string       nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (ps_bottom_out_flat !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, ps_bottom_out_flat, e);
            end
        end
    end

    initial begin
        logic [63:0] held;
        logic [63:0] wrap_ps;
        logic [63:0] wrap_exp;
        int          x;

        do_reset();
        do_reset();
        expect_const("reset_zero", '0);

        // Full accumulate: 4 rows of 3*2 summed down each column.
        repeat (4) shb(rep(16'd2));
        repeat (4) shr(rep(16'd3));
        repeat (4) shp('0);
        expect_const("accum_24", rep(16'h0018));

        do_reset();
        expect_const("reset_after_load", '0);

        repeat (4) shb(rep(16'd7));
        repeat (4) shr(rep(16'd9));
        repeat (2) shp(rep(16'd1));
        do_clear();
        expect_const("clear_zero", '0);

        // Pass-through with zero weights: 3 pulses not enough, 4th delivers.
        repeat (3) shp(64'h0103_0102_0101_0100);
        expect_const("pass_3_pulses", '0);
        shp(64'h0103_0102_0101_0100);
        expect_const("pass_4_pulses", 64'h0103_0102_0101_0100);

        // Wrap (or saturate) at the top row, zero products below it.
        do_clear();
        repeat (4) shb(rep(16'h0100));
        repeat (4) shr(rep(16'h0100));
        shb(rep(16'h0001));
        repeat (4) shr(64'h0100_0100_0100_0001);
`ifdef SYSTOLIC_PS_SATURATE_EN
        wrap_ps  = rep(16'h7FFF);
        wrap_exp = rep(16'h7FFF);
`else
        wrap_ps  = rep(16'hFFFF);
        wrap_exp = '0;
`endif
        repeat (4) shp(wrap_ps);
        expect_const("wrap_or_sat", wrap_exp);

        // Simultaneous shift-right and shift-bottom: MAC must see the old a.
        do_clear();
        repeat (4) shb(rep(16'd1));
        repeat (4) shr(rep(16'd5));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rep(16'd7), '0, '0);
        repeat (3) shp('0);
        expect_const("simul_old_a", 64'h0014_0014_0014_001A);

        held = 64'h0014_0014_0014_001A;
        repeat (10) idle();
        expect_const("hold_10", held);

        // Randomized mix including mid-operation reset and clear.
        for (int i = 0; i < 400; i++) begin
            x = $urandom_range(0, 99);
            step(x < 3, (x >= 3) && (x < 7), 1'($urandom), 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        @(negedge clk);
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
